sr_cpu_core: RTL and testbench

// - Single-cycle RV32 subset CPU (schoolRISCV style) with the packed-SIMD KSLL8 instruction.
// - Fetches one instruction per clock from an external combinational instruction ROM.
// - Exposes one register-file read port for debug and bench inspection.
// - KSLL8 reports saturation in x31[0].

---
 rtl/sr_cpu_core_if.sv | 11 +
 rtl/sr_cpu_core.sv | 145 ++++++++++++++
 tb/tb_sr_cpu_core.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_cpu_core_if.sv
// Instruction-fetch and debug register-read bus of sr_cpu_core.
// master = CPU side, slave = ROM / debugger side.
interface sr_cpu_core_if;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic [4:0]  regAddr;
    logic [31:0] regData;

    modport master (output imAddr, input imData, input regAddr, output regData);
    modport slave  (input imAddr, output imData, output regAddr, input regData);
endinterface

// File: rtl/sr_cpu_core.sv
// Single-cycle RV32 subset CPU with packed-SIMD KSLL8 (saturation flag in x31[0]).
// Optional feature macro: SR_CPU_MUL_EN adds RV32M mul.
module sr_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    sr_cpu_core_if.master   bus
);

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [31:0] w_instr;
    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_f7;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_b;
    logic        w_we;
    logic [31:0] w_wd;
    logic        w_ksll;
    logic        w_taken;
    logic [31:0] w_ksll_res;
    logic        w_ov;
    logic [31:0] w_pc_next;

    // One byte lane of KSLL8: {saturated, lane result}
    function automatic logic [8:0] ksll_lane(input logic [7:0] s, input logic [2:0] sh);
        logic [15:0] t;
        t = {{8{s[7]}}, s} << sh;
        if (t[15:7] == {9{t[7]}}) begin
            ksll_lane = {1'b0, t[7:0]};
        end else begin
            ksll_lane = {1'b1, (s[7] ? 8'h80 : 8'h7F)};
        end
    endfunction

    assign w_instr   = bus.imData;
    assign w_op      = w_instr[6:0];
    assign w_rd      = w_instr[11:7];
    assign w_f3      = w_instr[14:12];
    assign w_rs1     = w_instr[19:15];
    assign w_rs2     = w_instr[24:20];
    assign w_f7      = w_instr[31:25];
    assign w_imm_i   = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_u   = {w_instr[31:12], 12'h000};
    assign w_imm_b   = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};

    assign w_rs1_val   = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
    assign w_rs2_val   = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];
    assign bus.regData = (bus.regAddr == 5'd0) ? 32'h0 : r_regs[bus.regAddr];
    assign bus.imAddr  = {2'b00, r_pc[31:2]};
    assign w_pc_next   = w_taken ? (r_pc + w_imm_b) : (r_pc + 32'd4);

    // Packed KSLL8 datapath across the four byte lanes
    always_comb begin : ksll_dp
        logic [8:0] lane;
        lane       = 9'h000;
        w_ksll_res = 32'h0;
        w_ov       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane = ksll_lane(w_rs1_val[8*i +: 8], w_rs2_val[2:0]);
            w_ksll_res[8*i +: 8] = lane[7:0];
            w_ov = w_ov | lane[8];
        end
    end

    // Instruction decode, write-back data and branch resolution
    always_comb begin
        w_we    = 1'b0;
        w_wd    = 32'h0;
        w_ksll  = 1'b0;
        w_taken = 1'b0;
        case (w_op)
            7'b0110011: begin
                case ({w_f7, w_f3})
                    10'b0000000_000: begin w_we = 1'b1; w_wd = w_rs1_val + w_rs2_val; end
                    10'b0100000_000: begin w_we = 1'b1; w_wd = w_rs1_val - w_rs2_val; end
                    10'b0000000_110: begin w_we = 1'b1; w_wd = w_rs1_val | w_rs2_val; end
                    10'b0000000_101: begin w_we = 1'b1; w_wd = w_rs1_val >> w_rs2_val[4:0]; end
                    10'b0000000_011: begin w_we = 1'b1; w_wd = {31'h0, (w_rs1_val < w_rs2_val)}; end
`ifdef SR_CPU_MUL_EN
                    10'b0000001_000: begin w_we = 1'b1; w_wd = w_rs1_val * w_rs2_val; end
`endif
                    default: w_we = 1'b0;
                endcase
            end
            7'b0010011: begin
                if (w_f3 == 3'b000) begin
                    w_we = 1'b1;
                    w_wd = w_rs1_val + w_imm_i;
                end else begin
                    w_we = 1'b0;
                end
            end
            7'b0110111: begin
                w_we = 1'b1;
                w_wd = w_imm_u;
            end
            7'b1100011: begin
                case (w_f3)
                    3'b000:  w_taken = (w_rs1_val == w_rs2_val);
                    3'b001:  w_taken = (w_rs1_val != w_rs2_val);
                    default: w_taken = 1'b0;
                endcase
            end
            7'b1110111: begin
                if ({w_f7, w_f3} == 10'b0101110_000) begin
                    w_ksll = 1'b1;
                    w_we   = 1'b1;
                    w_wd   = w_ksll_res;
                end else begin
                    w_ksll = 1'b0;
                end
            end
            default: w_we = 1'b0;
        endcase
    end

    // PC and register file; the KSLL8 flag write to x31 is last so it wins over rd==x31
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                r_regs[i[4:0]] <= 32'h0;
            end
        end else begin
            r_pc <= w_pc_next;
            if (w_we && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_wd;
            end
            if (w_ksll) begin
                r_regs[31] <= {31'h0, w_ov};
            end
        end
    end

endmodule

// File: tb/tb_sr_cpu_core.sv
// Randomized self-checking bench for sr_cpu_core against an instruction-level reference model.
module tb_sr_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  reg_addr = 5'd0;
    logic [31:0] rom [256];
    int          pidx;
    int          nvec = 0;
    int          nerr = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    sr_cpu_core_if bus_if ();
    assign bus_if.imData  = rom[bus_if.imAddr[7:0]];
    assign bus_if.regAddr = reg_addr;

    sr_cpu_core #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;

    // ---------------- encoders / program building ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_ksll(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return enc_r(7'b0101110, rs2, rs1, 3'b000, rd, 7'b1110111);
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
        pidx = 0;
    endtask
    task automatic emit(input logic [31:0] ins);
        rom[pidx] = ins;
        pidx++;
    endtask
    task automatic emit_li(input logic [4:0] rd, input logic [31:0] val);
        logic [31:0] up;
        up = val + 32'h800;
        emit(enc_lui(rd, up[31:12]));
        emit(enc_addi(rd, rd, val[11:0]));
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32:0] ref_ksll8(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic        ov;
        logic [7:0]  bv;
        logic [7:0]  lane;
        int sh, s, t;
        res = 32'h0; ov = 1'b0;
        sh = int'(b % 32'd8);
        for (int i = 0; i < 4; i++) begin
            bv = 8'(a >> (8 * i));
            s = int'($signed(bv));
            t = s * (1 << sh);
            if (t > 127) begin lane = 8'h7F; ov = 1'b1; end
            else if (t < -128) begin lane = 8'h80; ov = 1'b1; end
            else lane = 8'(t);
            res[8*i +: 8] = lane;
        end
        return {ov, res};
    endfunction

    task automatic m_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask
    task automatic m_wr(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) m_regs[rd] = v;
    endtask
    task automatic m_step(input logic [31:0] ins);
        logic [4:0] rd;
        logic [31:0] a, b, nxt;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic [32:0] k;
        rd = ins[11:7];
        a = m_regs[ins[19:15]];
        b = m_regs[ins[24:20]];
        i12 = ins[31:20];
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        nxt = m_pc + 32'd4;
        if (ins[6:0] == 7'b0110011) begin
            if (ins[31:25] == 7'd0 && ins[14:12] == 3'd0) m_wr(rd, a + b);
            else if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'd0) m_wr(rd, a - b);
            else if (ins[31:25] == 7'd0 && ins[14:12] == 3'd6) m_wr(rd, a | b);
            else if (ins[31:25] == 7'd0 && ins[14:12] == 3'd5) m_wr(rd, a >> (b % 32'd32));
            else if (ins[31:25] == 7'd0 && ins[14:12] == 3'd3) m_wr(rd, (a < b) ? 32'd1 : 32'd0);
`ifdef SR_CPU_MUL_EN
            else if (ins[31:25] == 7'b0000001 && ins[14:12] == 3'd0) m_wr(rd, a * b);
`endif
        end else if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'd0) begin
            m_wr(rd, a + 32'(i12));
        end else if (ins[6:0] == 7'b0110111) begin
            m_wr(rd, {ins[31:12], 12'h000});
        end else if (ins[6:0] == 7'b1100011) begin
            if ((ins[14:12] == 3'd0 && a == b) || (ins[14:12] == 3'd1 && a != b))
                nxt = m_pc + 32'(b13);
        end else if (ins[6:0] == 7'b1110111 && ins[14:12] == 3'd0 && ins[31:25] == 7'b0101110) begin
            k = ref_ksll8(a, b);
            m_wr(rd, k[31:0]);
            m_regs[31] = {31'h0, k[32]};
        end
        m_pc = nxt;
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // Runs n cycles in lockstep with the model; reports the first fetch-address divergence
    task automatic run_cycles(input int n, output int bad, output logic [31:0] act, output logic [31:0] exp);
        bad = 0; act = 32'h0; exp = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (bus_if.imAddr !== {2'b00, m_pc[31:2]} && bad == 0) begin
                bad = 1; act = bus_if.imAddr; exp = {2'b00, m_pc[31:2]};
            end
            m_step(rom[m_pc[9:2]]);
            @(negedge clk);
        end
    endtask

    task automatic peek(input logic [4:0] r, output logic [31:0] v);
        @(negedge clk);
        reg_addr = r;
        #1;
        v = bus_if.regData;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] v;
        clear_prog();
        rst = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            nvec++;
            if (bus_if.imAddr !== 32'h0) begin nerr++; $display("FAIL reset_hold imAddr=%h want 0", bus_if.imAddr); end
        end
        rst = 1'b0;
        m_reset();
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (bus_if.imAddr !== 32'(k)) begin nerr++; $display("FAIL reset_fetch imAddr=%h want %h", bus_if.imAddr, k); end
            nvec++;
            if ($isunknown(bus_if.imData)) begin nerr++; $display("FAIL reset_imdata_x imData=%h want known", bus_if.imData); end
            @(negedge clk);
        end
        for (int r = 0; r < 32; r++) begin
            peek(5'(r), v);
            nvec++;
            if (v !== 32'h0) begin nerr++; $display("FAIL reset_reg x%0d=%h want 0", r, v); end
        end
    endtask

    task automatic test_ksll8_directed();
        logic [31:0] tx1 [7] = '{32'h40404040, 32'h20202020, 32'hC0C0C0C0, 32'hC0C0C0C0, 32'hD0D0D0D0, 32'h01FF7F80, 32'h20202020};
        logic [31:0] tx2 [7] = '{32'd1, 32'd1, 32'd2, 32'd1, 32'd9, 32'd1, 32'd1};
        logic [31:0] te10 [7] = '{32'h7F7F7F7F, 32'h40404040, 32'h80808080, 32'h80808080, 32'hA0A0A0A0, 32'h02FE7F80, 32'h0};
        logic [31:0] te31 [7] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0};
        logic [31:0] v10, v31, act, exp;
        logic [4:0] dst;
        int bad;
        for (int c = 0; c < 7; c++) begin
            dst = (c == 6) ? 5'd31 : 5'd10;
            clear_prog();
            emit_li(5'd20, 32'h40404040);
            emit_li(5'd21, 32'd1);
            emit(enc_ksll(5'd22, 5'd20, 5'd21));
            emit_li(5'd1, tx1[c]);
            emit_li(5'd2, tx2[c]);
            emit(enc_ksll(dst, 5'd1, 5'd2));
            do_reset();
            run_cycles(pidx + 2, bad, act, exp);
            nvec++;
            if (bad != 0) begin nerr++; $display("FAIL ksll_pc case%0d imAddr=%h want %h", c, act, exp); end
            peek(5'd10, v10);
            peek(5'd31, v31);
            nvec++;
            if (c != 6 && v10 !== te10[c]) begin nerr++; $display("FAIL ksll_res case%0d x10=%h want %h", c, v10, te10[c]); end
            nvec++;
            if (v31 !== te31[c]) begin nerr++; $display("FAIL ksll_ov case%0d x31=%h want %h", c, v31, te31[c]); end
            nvec++;
            if (v10 !== m_regs[10]) begin nerr++; $display("FAIL ksll_model case%0d x10=%h want %h", c, v10, m_regs[10]); end
        end
    endtask

    task automatic test_ksll8_random();
        logic [31:0] a, b, v10, v31, act, exp;
        int bad;
        for (int it = 0; it < 20; it++) begin
            a = $urandom;
            b = $urandom;
            clear_prog();
            emit_li(5'd1, a);
            emit_li(5'd2, b);
            emit(enc_ksll(5'd10, 5'd1, 5'd2));
            do_reset();
            run_cycles(pidx + 2, bad, act, exp);
            peek(5'd10, v10);
            peek(5'd31, v31);
            nvec++;
            if (v10 !== m_regs[10]) begin nerr++; $display("FAIL ksll_rand a=%h b=%h x10=%h want %h", a, b, v10, m_regs[10]); end
            nvec++;
            if (v31 !== m_regs[31]) begin nerr++; $display("FAIL ksll_rand_ov a=%h b=%h x31=%h want %h", a, b, v31, m_regs[31]); end
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] v, act, exp;
        logic [4:0] rd, r1, r2;
        int bad;
        for (int it = 0; it < 4; it++) begin
            clear_prog();
            for (int r = 1; r < 5; r++) emit_li(5'(r), $urandom);
            for (int k = 0; k < 30; k++) begin
                rd = 5'($urandom_range(0, 31));
                r1 = 5'($urandom_range(0, 8));
                r2 = 5'($urandom_range(0, 8));
                case ($urandom_range(0, 9))
                    0: emit(enc_r(7'b0000000, r2, r1, 3'b000, rd, 7'b0110011));
                    1: emit(enc_r(7'b0100000, r2, r1, 3'b000, rd, 7'b0110011));
                    2: emit(enc_r(7'b0000000, r2, r1, 3'b110, rd, 7'b0110011));
                    3: emit(enc_r(7'b0000000, r2, r1, 3'b101, rd, 7'b0110011));
                    4: emit(enc_r(7'b0000000, r2, r1, 3'b011, rd, 7'b0110011));
                    5: emit(enc_addi(rd, r1, 12'($urandom)));
                    6: emit(enc_lui(rd, 20'($urandom)));
                    7: emit(enc_ksll(rd, r1, r2));
                    8: emit({25'($urandom), 7'b1111111});
                    default: emit(enc_r(7'b0000001, r2, r1, 3'b000, rd, 7'b0110011));
                endcase
            end
            do_reset();
            run_cycles(pidx + 2, bad, act, exp);
            nvec++;
            if (bad != 0) begin nerr++; $display("FAIL alu_pc iter%0d imAddr=%h want %h", it, act, exp); end
            for (int r = 0; r < 32; r++) begin
                peek(5'(r), v);
                nvec++;
                if (v !== m_regs[r]) begin nerr++; $display("FAIL alu_rand iter%0d x%0d=%h want %h", it, r, v, m_regs[r]); end
            end
        end
    endtask

    task automatic test_branch_loop();
        logic [31:0] v5, v7, v8, act, exp;
        int bad;
        clear_prog();
        emit(enc_addi(5'd5, 5'd0, 12'd0));
        emit(enc_addi(5'd6, 5'd0, 12'd5));
        emit(enc_addi(5'd5, 5'd5, 12'd1));
        emit(enc_b(3'b001, 5'd5, 5'd6, -4));
        emit(enc_b(3'b000, 5'd0, 5'd0, 8));
        emit(enc_addi(5'd7, 5'd0, 12'd99));
        emit(enc_addi(5'd8, 5'd0, 12'd1));
        do_reset();
        run_cycles(18, bad, act, exp);
        nvec++;
        if (bad != 0) begin nerr++; $display("FAIL branch_pc imAddr=%h want %h", act, exp); end
        peek(5'd5, v5);
        peek(5'd7, v7);
        peek(5'd8, v8);
        nvec++;
        if (v5 !== 32'd5) begin nerr++; $display("FAIL branch_x5 x5=%h want 5", v5); end
        nvec++;
        if (v7 !== 32'd0) begin nerr++; $display("FAIL branch_skip x7=%h want 0", v7); end
        nvec++;
        if (v8 !== 32'd1) begin nerr++; $display("FAIL branch_target x8=%h want 1", v8); end
    endtask

    task automatic test_x0_and_mul();
        logic [31:0] v0, v3, act, exp, want;
        int bad;
        clear_prog();
        emit(enc_addi(5'd0, 5'd0, 12'd123));
        emit(enc_lui(5'd0, 20'hABCDE));
        emit(enc_addi(5'd1, 5'd0, 12'd7));
        emit(enc_addi(5'd2, 5'd0, 12'd6));
        emit(enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011));
        do_reset();
        run_cycles(pidx + 2, bad, act, exp);
        peek(5'd0, v0);
        peek(5'd3, v3);
        nvec++;
        if (v0 !== 32'h0) begin nerr++; $display("FAIL x0_write x0=%h want 0", v0); end
`ifdef SR_CPU_MUL_EN
        want = 32'd42;
`else
        want = 32'd0;
`endif
        nvec++;
        if (v3 !== want) begin nerr++; $display("FAIL mul x3=%h want %h", v3, want); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v, act, exp;
        int bad;
        clear_prog();
        for (int k = 0; k < 40; k++) emit(enc_addi(5'd1, 5'd1, 12'd1));
        do_reset();
        run_cycles(10, bad, act, exp);
        reg_addr = 5'd1;
        #1;
        nvec++;
        if (bus_if.regData !== 32'd10) begin nerr++; $display("FAIL mid_pre x1=%h want a", bus_if.regData); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (bus_if.imAddr !== 32'h0) begin nerr++; $display("FAIL mid_reset imAddr=%h want 0", bus_if.imAddr); end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        nvec++;
        if (bus_if.regData !== 32'd0) begin nerr++; $display("FAIL mid_clear x1=%h want 0", bus_if.regData); end
        run_cycles(3, bad, act, exp);
        nvec++;
        if (bad != 0) begin nerr++; $display("FAIL mid_restart imAddr=%h want %h", act, exp); end
        #1;
        nvec++;
        if (bus_if.regData !== 32'd3) begin nerr++; $display("FAIL mid_post x1=%h want 3", bus_if.regData); end
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_ksll8_directed();
        test_ksll8_random();
        test_alu_random();
        test_branch_loop();
        test_x0_and_mul();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
